// File: rtl/rf_dump_pkg.sv
// rf_dump_pkg: shared types and default sizing for the register-file dump engine.
//   - state_t : dump FSM encoding (ST_CSUM only exists when RF_DUMP_CSUM_EN is defined)
//   - DEF_*   : default register count, data width and select width
package rf_dump_pkg;

    localparam int DEF_NUM_REGS = 8;
    localparam int DEF_DATA_W   = 16;
    localparam int DEF_SEL_W    = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_SEND,
        ST_FIN
`ifdef RF_DUMP_CSUM_EN
        ,
        ST_CSUM
`endif
    } state_t;

endpackage

// File: rtl/rf_dump_csum.sv
// rf_dump_csum: running modulo-2^DATA_W sum of the values captured during one dump.
// Only instantiated when RF_DUMP_CSUM_EN is defined.
//   clk, rst    : clock, async active-low reset
//   clr         : dump accepted, restart the sum
//   add_en      : a register value is being captured this cycle
//   add_data    : value being captured
//   sum         : accumulated checksum
module rf_dump_csum #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              add_en,
    input  logic [DATA_W-1:0] add_data,
    output logic [DATA_W-1:0] sum
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        sum <= '0;
        else if (clr)    sum <= '0;
        else if (add_en) sum <= sum + add_data;
    end

endmodule

// File: rtl/rf_dump.sv
// rf_dump: walks registers 0..NUM_REGS-1 through one register-file read port and
// streams each value on a valid/ready interface tagged with its register number.
// Optional feature macro: RF_DUMP_CSUM_EN appends a checksum word (regnum 0,
// data = sum of dumped values) which then carries out_last.
//   clk, rst         : clock, async active-low reset
//   start            : one-cycle dump request (err pulse if a dump is running)
//   regsel / rddata  : read-select out, bypassed read data in
//   out_valid/ready  : stream handshake; out_data, out_regnum, out_last payload
//   busy, done, err  : status; done/err are one-cycle pulses
// Every output is a flop; out_ready only steers next-state logic.
module rf_dump
    import rf_dump_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int SEL_W    = DEF_SEL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [SEL_W-1:0]  regsel,
    input  logic [DATA_W-1:0] rddata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [SEL_W-1:0]  out_regnum,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_REGS - 1);

    state_t state;
    logic   at_last_idx;

    // regsel doubles as the walk index
    assign at_last_idx = (regsel == LAST_IDX);

`ifdef RF_DUMP_CSUM_EN
    logic [DATA_W-1:0] csum;

    rf_dump_csum #(.DATA_W(DATA_W)) u_csum (
        .clk      (clk),
        .rst      (rst),
        .clr      (state == ST_IDLE && start),
        .add_en   (state == ST_READ),
        .add_data (rddata),
        .sum      (csum)
    );
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            regsel     <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_regnum <= '0;
            out_last   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            // a request that arrives while we are not idle (incl. FIN) is rejected
            err  <= start && (state != ST_IDLE);
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        regsel <= '0;
                        busy   <= 1'b1;
                        state  <= ST_READ;
                    end
                end
                ST_READ: begin
                    out_data   <= rddata;
                    out_regnum <= regsel;
                    out_valid  <= 1'b1;
`ifdef RF_DUMP_CSUM_EN
                    out_last   <= 1'b0;  // the checksum word is last instead
`else
                    out_last   <= at_last_idx;
`endif
                    state      <= ST_SEND;
                end
                ST_SEND: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        if (out_last) begin
                            state <= ST_FIN;
`ifdef RF_DUMP_CSUM_EN
                        end else if (at_last_idx) begin
                            state <= ST_CSUM;
`endif
                        end else begin
                            regsel <= regsel + SEL_W'(1);
                            state  <= ST_READ;
                        end
                    end
                end
`ifdef RF_DUMP_CSUM_EN
                ST_CSUM: begin
                    // sum already includes the final register captured in its READ
                    out_data   <= csum;
                    out_regnum <= '0;
                    out_last   <= 1'b1;
                    out_valid  <= 1'b1;
                    state      <= ST_SEND;
                end
`endif
                ST_FIN: begin
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    regsel <= '0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/rf_dump.md
# rf_dump

Sequential read-out engine for the 8 x 16-bit register file. On a `start` pulse it walks register numbers 0..7 through one register-file read port and streams each value out on a valid/ready interface, tagged with its register number. It sits beside the register file's write port and is used for debug dumps and context save. It only reads, so it never modifies architectural state.

## Interface
- `NUM_REGS`, 8: registers dumped per sequence, which are registers 0..NUM_REGS-1.
- `DATA_W`, 16: register and stream data width.
- `SEL_W`, 3: register-select width. Must equal clog2(NUM_REGS).
- `clk` in 1: the block's single clock.
- `rst` in 1: asynchronous, active-low reset. The block is held in reset while `rst` = 0.
- `start` in 1: single-cycle request to begin a dump.
- `regsel` out SEL_W: register number driven to the register-file read-select input.
- `rddata` in DATA_W: combinational (bypassed) read data for `regsel`.
- `out_valid` out 1: stream word valid.
- `out_ready` in 1: downstream accepts the word.
- `out_data` out DATA_W: stream word.
- `out_regnum` out SEL_W: register number of `out_data`.
- `out_last` out 1: marks the final word of the sequence.
- `busy` out 1: a dump is in progress.
- `done` out 1: one-cycle pulse after the last word is accepted.
- `err` out 1: one-cycle pulse when `start` arrives while `busy` = 1.

## Operation
- FSM states: IDLE, READ, SEND, FIN.
- IDLE: `start` = 1 → index := 0, go to READ.
- READ: capture `rddata` into `out_data`. Set `out_regnum` := index, `out_valid` := 1, `out_last` := (index == NUM_REGS-1), then go to SEND.
- SEND: hold all outputs stable until `out_valid` && `out_ready`. On that handshake:
  - not last → index++, `out_valid` := 0, go to READ.
  - last → `out_valid` := 0, go to FIN.
- FIN: pulse `done` for one cycle, then return to IDLE.
- `regsel` always equals index. It is 0 in IDLE.
- `busy` = 1 in READ, SEND and FIN.
- `start` while `busy`: the request is ignored, `err` pulses for one cycle, and the sequence in progress is unaffected.
- `out_ready` is a don't-care while `out_valid` = 0.
- Snapshot semantics: each value is the register content in that register's READ cycle. A write to the same register in that cycle is seen via the register file's bypass. Later writes to an already captured register are not reflected.
- The index counter never wraps. The sequence ends at NUM_REGS-1.

## Timing
- Reset: state IDLE, index 0, `regsel` 0, `out_valid` 0, `out_data` 0, `out_regnum` 0, `out_last` 0, `busy` 0, `done` 0, `err` 0.
- Reset asserted mid-dump aborts immediately. No `done` is produced and the stream word is dropped.
- `start` at cycle T → READ at T+1 → first `out_valid` = 1 at T+2.
- Each word takes a minimum of 2 cycles: READ plus SEND with `out_ready` held at 1.
- Full dump with `out_ready` tied to 1: `done` pulses at T+2·NUM_REGS+2.
- `start` in the same cycle as the `done` pulse (FIN) is an `err` case. The first new `start` that is accepted is one in IDLE.
- All outputs are registered. There is no combinational path from `out_ready` to any output.

## Configuration
- `RF_DUMP_CSUM_EN` defined:
  - After word NUM_REGS-1, one extra word is sent. Its `out_data` = modulo-2^DATA_W sum of all dumped values and its `out_regnum` = 0.
  - `out_last` moves to this checksum word.
  - `done` is delayed by 2 cycles.
- `RF_DUMP_CSUM_EN` undefined: no checksum word, and no accumulator logic is synthesized.

## Structure
- Package `rf_dump_pkg` holds:
  - the FSM state typedef, including the CSUM state under the macro;
  - the default widths and count constants.
- One sub-module, `rf_dump_csum`:
  - 16-bit accumulator;
  - clears on `start` acceptance;
  - adds on each READ capture;
  - instantiated only under `RF_DUMP_CSUM_EN`.

## Test plan
- Registers preloaded with 0x1111·(n+1), `start`, `out_ready` = 1 → 8 words 0x1111..0x8888 with regnums 0..7, `out_last` on word 7, `done` at cycle T+18.
- `out_ready` toggles 1/0 randomly → same 8 values in order, none duplicated or dropped, and `out_data` stable while stalled.
- `start` pulses again while on word 3 → `err` for one cycle, and the stream still completes with exactly 8 words.
- Write 0xBEEF to r5 in r5's READ cycle → word 5 = 0xBEEF. Write 0xDEAD to r2 after r2's capture → word 2 keeps the old value.
- `rst` = 0 during word 4's SEND → all outputs reach reset values asynchronously, and no `done` is produced. A new `start` after release dumps from r0.
- With `RF_DUMP_CSUM_EN` and registers 0xFFFF,1,0,0,0,0,0,0 → 9th word 0x0000 (wrap-around), with `out_last` on it.
